accel_spi_reader: RTL and testbench

- SPI master for the on-board 3-axis accelerometer, one stage upstream of the Y-axis seven-segment driver.
- After reset it waits out power-up, programs the sensor's configuration registers, then polls the Y-axis data registers at a fixed rate.
- Delivers a 10-bit two's-complement Y sample plus a synchronized copy of the sensor's INT2 line, the exact pair the display stage consumes as A_num / A_int2.

---
 rtl/accel_pkg.sv | 42 ++++
 rtl/spi_xfer_engine.sv | 80 ++++++++
 rtl/accel_spi_reader.sv | 137 +++++++++++++
 tb/tb_accel_spi_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants for the accelerometer SPI reader: register map,
// power-up configuration table, read command and FSM states.
package accel_pkg;

  localparam logic [5:0] DATA_FORMAT = 6'h31;
  localparam logic [5:0] BW_RATE     = 6'h2C;
  localparam logic [5:0] INT_MAP     = 6'h2F;
  localparam logic [5:0] INT_ENABLE  = 6'h2E;
  localparam logic [5:0] POWER_CTL   = 6'h2D;
  localparam logic [5:0] DATAY0      = 6'h34;

  // R=1, MB=1 so DATAY0 and DATAY1 stream out in one frame
  localparam logic [7:0] READ_CMD = {1'b1, 1'b1, DATAY0};

  localparam int INIT_LEN = 5;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } init_entry_t;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_INIT_XFER,
    ST_INIT_GAP,
    ST_IDLE,
    ST_READ_XFER,
    ST_UPDATE
  } state_t;

  // POWER_CTL goes last so the part only starts measuring once configured
  function automatic init_entry_t init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    init_entry = '{addr: DATA_FORMAT, data: 8'h00};
      3'd1:    init_entry = '{addr: BW_RATE,     data: 8'h0A};
      3'd2:    init_entry = '{addr: INT_MAP,     data: 8'h80};
      3'd3:    init_entry = '{addr: INT_ENABLE,  data: 8'h80};
      default: init_entry = '{addr: POWER_CTL,   data: 8'h08};
    endcase
  endfunction

endpackage

// File: rtl/spi_xfer_engine.sv
// SPI mode-3 frame engine: shifts out nbytes of tx_word MSB-first, captures
// MISO into rx_word, and enforces CS setup/hold and the inter-frame gap.
module spi_xfer_engine #(
  parameter int SCLK_HALF = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  nbytes,
  input  logic [23:0] tx_word,
  input  logic        spi_miso,
  output logic        busy,
  output logic        done,
  output logic [23:0] rx_word,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  localparam int DW = $clog2(SCLK_HALF);
  localparam logic [DW-1:0] DIV_END = DW'(SCLK_HALF - 1);

  logic [DW-1:0] div;
  logic [5:0]    hp;      // half-period index within the frame
  logic [5:0]    nbits2;  // 2 * bit count
  logic [23:0]   sh;

  // Half-periods 0..nbits2-1 carry SCLK edges (even = fall, odd = rise),
  // nbits2 releases CS, and two more half-periods form the CS-high gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_word  <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b1;
      spi_mosi <= 1'b1;
      div      <= '0;
      hp       <= '0;
      nbits2   <= '0;
      sh       <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          spi_cs_n <= 1'b0;
          spi_sclk <= 1'b1;
          sh       <= tx_word;
          nbits2   <= (nbytes == 2'd3) ? 6'd48 : 6'd32;
          rx_word  <= '0;
          div      <= '0;
          hp       <= '0;
        end
      end else if (div == DIV_END) begin
        div <= '0;
        hp  <= hp + 6'd1;
        if (hp < nbits2) begin
          if (!hp[0]) begin
            spi_sclk <= 1'b0;
            spi_mosi <= sh[23];
            sh       <= {sh[22:0], 1'b1};
          end else begin
            spi_sclk <= 1'b1;
            rx_word  <= {rx_word[22:0], spi_miso};
          end
        end else if (hp == nbits2) begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b1;
        end else if (hp == nbits2 + 6'd2) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// Accelerometer front end: power-up wait, register init, then fixed-rate
// Y-axis polling producing a 10-bit sample and synchronized INT2.
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter int SCLK_HALF      = 25,
  parameter int STARTUP_CYCLES = 100000,
  parameter int POLL_CYCLES    = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_miso,
  input  logic       int2_in,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic [9:0] y_num,
  output logic       y_int2,
  output logic       y_valid,
  output logic       init_done
);

  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam logic [SW-1:0] STARTUP_END = SW'(STARTUP_CYCLES - 1);
  localparam logic [PW-1:0] POLL_END    = PW'(POLL_CYCLES - 1);

  state_t      state;
  logic [SW-1:0] startup_cnt;
  logic [PW-1:0] poll_cnt;
  logic [2:0]  idx;
  logic        int2_meta;

  logic        xfer_start, xfer_busy, xfer_done;
  logic [1:0]  xfer_nbytes;
  logic [23:0] xfer_tx, xfer_rx;
  init_entry_t next_entry;

  logic startup_end, poll_end, init_last;
  logic unused_xfer;

  assign startup_end = (state == ST_STARTUP) && (startup_cnt == STARTUP_END);
  assign poll_end    = (poll_cnt == POLL_END);
  assign init_last   = (idx == 3'(INIT_LEN - 1));
  assign unused_xfer = ^{xfer_busy, xfer_rx[23:16], xfer_rx[7:2]};

  // Start is decoded on the same edge as the FSM transition so CS falls with
  // zero added latency; this keeps read starts exactly POLL_CYCLES apart.
  always_comb begin
    next_entry  = init_entry((state == ST_INIT_GAP) ? idx + 3'd1 : 3'd0);
    xfer_start  = 1'b0;
    xfer_nbytes = 2'd2;
    xfer_tx     = {next_entry.addr[5:0] & 6'h3F, next_entry.data, 8'hFF} | 24'h0;
    xfer_tx[23:22] = 2'b00;
    if (startup_end || (state == ST_INIT_GAP && !init_last)) begin
      xfer_start = 1'b1;
    end else if (state == ST_IDLE && poll_end) begin
      xfer_start  = 1'b1;
      xfer_nbytes = 2'd3;
      xfer_tx     = {READ_CMD, 16'hFFFF};
    end
  end

  spi_xfer_engine #(.SCLK_HALF(SCLK_HALF)) u_xfer (
    .clk      (clk),
    .rst      (rst),
    .start    (xfer_start),
    .nbytes   (xfer_nbytes),
    .tx_word  (xfer_tx),
    .spi_miso (spi_miso),
    .busy     (xfer_busy),
    .done     (xfer_done),
    .rx_word  (xfer_rx),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_STARTUP;
      startup_cnt <= '0;
      poll_cnt    <= '0;
      idx         <= '0;
      y_num       <= '0;
      y_valid     <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      // poll timer free-runs through the read so the rate ignores frame length
      if (state == ST_IDLE || state == ST_READ_XFER || state == ST_UPDATE)
        poll_cnt <= poll_end ? '0 : poll_cnt + 1'b1;
      case (state)
        ST_STARTUP: begin
          if (startup_end) begin
            idx   <= '0;
            state <= ST_INIT_XFER;
          end else begin
            startup_cnt <= startup_cnt + 1'b1;
          end
        end
        ST_INIT_XFER: if (xfer_done) state <= ST_INIT_GAP;
        ST_INIT_GAP: begin
          if (init_last) begin
            init_done <= 1'b1;
            poll_cnt  <= '0;
            state     <= ST_IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_INIT_XFER;
          end
        end
        ST_IDLE: if (poll_end) state <= ST_READ_XFER;
        ST_READ_XFER: begin
          if (xfer_done) begin
            y_num   <= {xfer_rx[1:0], xfer_rx[15:8]};
            y_valid <= 1'b1;
            state   <= ST_UPDATE;
          end
        end
        ST_UPDATE: state <= ST_IDLE;
        default:   state <= ST_STARTUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int2_meta <= 1'b0;
      y_int2    <= 1'b0;
    end else begin
      int2_meta <= int2_in;
      y_int2    <= int2_meta;
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Randomized scoreboard bench for accel_spi_reader with a behavioural
// sensor model on the SPI pins.
module tb_accel_spi_reader;
  localparam int SCLK_HALF = 2, STARTUP_CYCLES = 20, POLL_CYCLES = 400;

  logic clk = 0, rst = 0, spi_miso = 1, int2_in = 0;
  logic spi_cs_n, spi_sclk, spi_mosi, y_int2, y_valid, init_done;
  logic [9:0] y_num;

  always #5 clk = ~clk;

  accel_spi_reader #(.SCLK_HALF(SCLK_HALF), .STARTUP_CYCLES(STARTUP_CYCLES),
                     .POLL_CYCLES(POLL_CYCLES)) dut (
    .clk(clk), .rst(rst), .spi_miso(spi_miso), .int2_in(int2_in),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .y_num(y_num), .y_int2(y_int2), .y_valid(y_valid), .init_done(init_done));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  typedef struct { int len; logic [23:0] bits; } frame_t;
  frame_t     exp_frames[$];
  logic [9:0] exp_y[$];
  logic [15:0] resp_q[$];   // {DATAY0, DATAY1}
  logic [15:0] wr_tab [5] = '{16'h3100, 16'h2C0A, 16'h2F80, 16'h2E80, 16'h2D08};

  // Sample is the low 10 bits of DATAY1*256 + DATAY0 (two's complement)
  function automatic logic [9:0] y_model(input logic [7:0] d0, input logic [7:0] d1);
    int v;
    v = int'(d1 % 4) * 256 + int'(d0);
    return v[9:0];
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  // sensor model
  logic [23:0] rdata, mosi_sh;
  logic [15:0] pair;
  int fall_n, rise_n;
  frame_t ef;

  always @(negedge spi_cs_n) begin
    fall_n = 0; rise_n = 0; mosi_sh = '0; rdata = 24'hFFFFFF;
    if (init_done === 1'b1 && !rst) begin
      pair = (resp_q.size() != 0) ? resp_q.pop_front() : 16'($urandom);
      rdata = {8'h00, pair};
      exp_y.push_back(y_model(pair[15:8], pair[7:0]));
    end
  end

  always @(negedge spi_sclk) if (spi_cs_n === 1'b0) begin
    if (fall_n < 24) spi_miso = rdata[23 - fall_n];
    fall_n++;
  end

  always @(posedge spi_sclk) if (spi_cs_n === 1'b0) begin
    mosi_sh = {mosi_sh[22:0], spi_mosi};
    rise_n++;
  end

  always @(posedge spi_cs_n) if (!rst) begin
    if (exp_frames.size() == 0) fail_now("frame_unexpected");
    else begin
      ef = exp_frames.pop_front();
      check("frame_len", rise_n, ef.len);
      check("frame_data", mosi_sh, ef.bits);
    end
  end

  // read-rate monitor
  int reads = 0, init_cyc = 0, last_fall = 0;
  bit have_last = 0;
  always @(posedge init_done) begin init_cyc = cyc; have_last = 0; end
  always @(negedge spi_cs_n) if (init_done === 1'b1 && !rst) begin
    reads++;
    if (have_last) check("poll_interval", cyc - last_fall, POLL_CYCLES);
    else           check("first_read_delay", cyc - init_cyc, POLL_CYCLES);
    have_last = 1;
    last_fall = cyc;
  end

  // output monitor
  int vcount = 0;
  logic prev_valid = 0;
  always @(negedge clk) begin
    if (!rst && y_valid === 1'b1) begin
      vcount++;
      check("y_valid_width", prev_valid, 0);
      if (exp_y.size() == 0) fail_now("y_valid_unexpected");
      else check("y_num", y_num, exp_y.pop_front());
    end
    prev_valid = y_valid;
  end

  task automatic push_writes();
    for (int i = 0; i < 5; i++) exp_frames.push_back('{16, {8'h00, wr_tab[i]}});
  endtask

  task automatic probe_int2(input string tag);
    logic old, nw;
    old = int2_in;
    nw  = ~old;
    @(posedge clk);
    #3 int2_in = nw;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_int2_hold"}, y_int2, old);
    @(negedge clk);
    check({tag, "_int2_follow"}, y_int2, nw);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (init_done !== 1'b1) fail_now({tag, "_init_timeout"});
  endtask

  task automatic wait_cs_low(input string tag);
    int n = 0;
    while (spi_cs_n !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    if (spi_cs_n !== 1'b0) fail_now({tag, "_cs_timeout"});
  endtask

  task automatic wait_valid(input int target, input int budget, input string tag);
    int n = 0;
    while (vcount < target && n < budget) begin @(negedge clk); n++; end
    if (vcount < target) fail_now({tag, "_valid_timeout"});
  endtask

  initial begin
    int cs_hi;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 1);
    check("rst_mosi", spi_mosi, 1);
    check("rst_y_num", y_num, 0);
    check("rst_y_int2", y_int2, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_init_done", init_done, 0);

    push_writes();
    resp_q.push_back(16'h2CFE);
    resp_q.push_back(16'hFF01);
    resp_q.push_back(16'h0002);
    for (int i = 0; i < 5; i++) resp_q.push_back(16'($urandom_range(0, 65535)));

    rst = 0;
    cs_hi = (spi_cs_n === 1'b1) ? 1 : 0;
    for (int i = 0; i < STARTUP_CYCLES - 1; i++) begin
      @(negedge clk);
      if (spi_cs_n === 1'b1) cs_hi++;
    end
    check("startup_cs_high", cs_hi, STARTUP_CYCLES);
    @(negedge clk);
    check("startup_cs_fall", spi_cs_n, 0);

    wait_init("first");
    check("init_frames_left", exp_frames.size(), 0);
    for (int i = 0; i < 8; i++) exp_frames.push_back('{24, {8'hF4, 16'hFFFF}});

    wait_cs_low("midread");
    repeat (10) @(negedge clk);
    probe_int2("midread");

    wait_valid(8, 4000, "poll");
    check("reads_vs_valid", vcount, reads);

    // abort a read during byte 1
    wait_cs_low("abort");
    repeat (44) @(negedge clk);
    #2 rst = 1;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 1);
    check("abort_y_num", y_num, 0);
    check("abort_init_done", init_done, 0);
    exp_frames.delete();
    exp_y.delete();
    repeat (3) @(negedge clk);
    push_writes();
    exp_frames.push_back('{24, {8'hF4, 16'hFFFF}});
    rst = 0;
    probe_int2("startup");
    wait_init("second");
    check("reinit_frames_left", exp_frames.size() == 1, 1);
    wait_valid(vcount + 1, 1000, "post_reset");
    check("final_exp_y_left", exp_y.size(), 0);
    check("final_frames_left", exp_frames.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
